// File: rtl/reg_file_sb.sv
// Parametrised register file with two write ports, write-to-read bypass and a
// per-register scoreboard of pending writes with a registered busy count.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             wr0_ok, wr1_ok, set_ok;

    // Register 0 is neither written nor marked busy when it is hardwired zero.
    assign wr0_ok = wr0_en && ((ZERO_REG == 0) || (wr0_addr != '0));
    assign wr1_ok = wr1_en && ((ZERO_REG == 0) || (wr1_addr != '0));
    assign set_ok = sb_set && ((ZERO_REG == 0) || (sb_addr != '0));

    // NOTE: this array is architectural state that must read zero after reset,
    // so every entry takes the async reset instead of being left to a RAM macro.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            if (wr0_ok) regs_q[wr0_addr] <= wr0_data;
            // NOTE: non-blocking updates take the last assignment, so port 1 wins a same-address collision.
            if (wr1_ok) regs_q[wr1_addr] <= wr1_data;
        end
    end

    // NOTE: busy_d starts as a copy of busy_q so every path assigns it and no latch is inferred.
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (set_ok && (sb_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wr0_ok && (wr0_addr == AW'(r))) || (wr1_ok && (wr1_addr == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[k*AW +: AW];

        // A same-cycle write both forwards its data and hides the pending-write flag.
        always_comb begin
            data = regs_q[addr];
            busy = busy_q[addr];
            if (wr1_ok && (wr1_addr == addr)) begin
                data = wr1_data;
                busy = 1'b0;
            end else if (wr0_ok && (wr0_addr == addr)) begin
                data = wr0_data;
                busy = 1'b0;
            end
            if (!reset_n || ((ZERO_REG != 0) && (addr == '0))) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en, wr1_en, sb_set, flush;
    logic [AW-1:0]       wr0_addr, wr1_addr, sb_addr;
    logic [XLEN-1:0]     wr0_data, wr1_data;
    logic [AW:0]         busy_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    // Architectural effect of one rising edge, taken straight from the rules.
    function automatic void model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (wr0_en && wr0_addr != 0) m_regs[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_regs[wr1_addr] = wr1_data;
        if (flush) begin
            for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
        end else begin
            if (wr0_en) m_busy[wr0_addr] = 1'b0;
            if (wr1_en) m_busy[wr1_addr] = 1'b0;
            if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic logic [NRD*XLEN-1:0] exp_data();
        logic [NRD*XLEN-1:0] d = '0;
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rd_addr[k*AW +: AW]);
            if (!reset_n || a == 0)            d[k*XLEN +: XLEN] = '0;
            else if (wr1_en && wr1_addr == a)  d[k*XLEN +: XLEN] = wr1_data;
            else if (wr0_en && wr0_addr == a)  d[k*XLEN +: XLEN] = wr0_data;
            else                               d[k*XLEN +: XLEN] = m_regs[a];
        end
        return d;
    endfunction

    function automatic logic [NRD-1:0] exp_busy();
        logic [NRD-1:0] b = '0;
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rd_addr[k*AW +: AW]);
            b[k] = reset_n && a != 0 && m_busy[a]
                   && !(wr1_en && wr1_addr == a) && !(wr0_en && wr0_addr == a);
        end
        return b;
    endfunction

    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        sb_set = 0; sb_addr = 0; flush = 0;
    endtask

    task automatic clock_edge();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        model_reset();
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h1234_5678;
        rd_addr = {5'd7, 5'd3};
        @(negedge clock); #1;
        n_total++;
        if (rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0", rd_data); else n_pass++;
        n_total++;
        if (busy_cnt !== '0) $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); else n_pass++;
        clock_edge();
        idle();
        reset_n = 1;
        #1;
        n_total++;
        if (rd_data !== '0 || rd_busy !== '0)
            $display("FAIL post_reset_read: got data %h busy %b expected 0/00", rd_data, rd_busy);
        else n_pass++;
        n_total++;
        if (busy_cnt !== '0) $display("FAIL post_reset_cnt: got %0d expected 0", busy_cnt); else n_pass++;
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
        clock_edge();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        n_total++;
        if (rd_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL write_then_read: got %h expected deadbeef", rd_data[31:0]); else n_pass++;
    endtask

    task automatic test_bypass();
        idle();
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h22;
        rd_addr = {5'd9, 5'd9};
        #1;
        n_total++;
        if (rd_data !== {32'h22, 32'h22}) $display("FAIL bypass_priority: got %h expected 22/22", rd_data); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_total++;
        if (rd_data[31:0] !== 32'h22) $display("FAIL stored_priority: got %h expected 22", rd_data[31:0]); else n_pass++;
        wr1_en = 1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
        rd_addr = {5'd9, 5'd0};
        #1;
        n_total++;
        if (rd_data[31:0] !== '0) $display("FAIL zero_reg_bypass: got %h expected 0", rd_data[31:0]); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_total++;
        if (rd_data[31:0] !== '0) $display("FAIL zero_reg_stored: got %h expected 0", rd_data[31:0]); else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle();
        sb_set = 1; sb_addr = 5'd4;
        rd_addr = {5'd0, 5'd4};
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b0) $display("FAIL busy_same_cycle: got %b expected 0", rd_busy[0]); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1)
            $display("FAIL sb_set_x4: got busy %b cnt %0d expected 1/1", rd_busy[0], busy_cnt);
        else n_pass++;
        wr1_en = 1; wr1_addr = 5'd4; wr1_data = 32'h55;
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55)
            $display("FAIL writeback_bypass_x4: got busy %b data %h expected 0/55", rd_busy[0], rd_data[31:0]);
        else n_pass++;
        clock_edge();
        idle();
        #1;
        n_total++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00)
            $display("FAIL writeback_clear_x4: got cnt %0d busy %b expected 0/00", busy_cnt, rd_busy);
        else n_pass++;
    endtask

    task automatic test_collision();
        idle();
        sb_set = 1; sb_addr = 5'd6;
        clock_edge();
        idle();
        wr0_en = 1; wr0_addr = 5'd6; wr0_data = 32'h66;
        sb_set = 1; sb_addr = 5'd6;
        clock_edge();
        idle();
        rd_addr = {5'd0, 5'd6};
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || rd_data[31:0] !== 32'h66)
            $display("FAIL set_beats_clear: got busy %b cnt %0d data %h expected 1/1/66", rd_busy[0], busy_cnt, rd_data[31:0]);
        else n_pass++;
        wr1_en = 1; wr1_addr = 5'd6; wr1_data = 32'h67;
        clock_edge();
        idle();
        #1;
        n_total++;
        if (busy_cnt !== 6'd0) $display("FAIL clear_x6: got %0d expected 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        idle();
        for (int r = 1; r <= 3; r++) begin
            sb_set = 1; sb_addr = AW'(r);
            clock_edge();
        end
        idle();
        #1;
        n_total++;
        if (busy_cnt !== 6'd3) $display("FAIL three_busy: got %0d expected 3", busy_cnt); else n_pass++;
        flush = 1; sb_set = 1; sb_addr = 5'd8;
        clock_edge();
        idle();
        rd_addr = {5'd1, 5'd8};
        #1;
        n_total++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00)
            $display("FAIL flush_beats_set: got cnt %0d busy %b expected 0/00", busy_cnt, rd_busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        idle();
        wr0_en = 1; wr0_addr = 5'd10; wr0_data = 32'hA5A5_A5A5;
        sb_set = 1; sb_addr = 5'd12;
        clock_edge();
        idle();
        sb_set = 1; sb_addr = 5'd13;
        clock_edge();
        idle();
        rd_addr = {5'd12, 5'd10};
        #1;
        n_total++;
        if (busy_cnt !== 6'd2 || rd_busy !== 2'b10 || rd_data[31:0] !== 32'hA5A5_A5A5)
            $display("FAIL pre_async_state: got cnt %0d busy %b data %h expected 2/10/a5a5a5a5", busy_cnt, rd_busy, rd_data[31:0]);
        else n_pass++;
        #1 reset_n = 0;
        model_reset();
        #1;
        n_total++;
        if (busy_cnt !== '0 || rd_busy !== '0 || rd_data !== '0)
            $display("FAIL async_reset: got cnt %0d busy %b data %h expected all 0", busy_cnt, rd_busy, rd_data);
        else n_pass++;
        @(negedge clock);
        reset_n = 1;
        #1;
        n_total++;
        if (rd_data[31:0] !== '0) $display("FAIL reg_cleared_by_reset: got %h expected 0", rd_data[31:0]); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr0_en   = ($urandom_range(0, 9) < 4);
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_en   = ($urandom_range(0, 9) < 4);
            wr1_addr = AW'($urandom_range(0, 7));
            wr1_data = $urandom;
            sb_set   = ($urandom_range(0, 9) < 5);
            sb_addr  = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 19) == 0);
            rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            n_total++;
            if (rd_data !== exp_data()) $display("FAIL rand_rd_data[%0d]: got %h expected %h", i, rd_data, exp_data()); else n_pass++;
            n_total++;
            if (rd_busy !== exp_busy()) $display("FAIL rand_rd_busy[%0d]: got %b expected %b", i, rd_busy, exp_busy()); else n_pass++;
            n_total++;
            if (int'(busy_cnt) != m_count()) $display("FAIL rand_busy_cnt[%0d]: got %0d expected %0d", i, busy_cnt, m_count()); else n_pass++;
            clock_edge();
        end
        idle();
    endtask

    initial begin
        idle();
        rd_addr = '0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor of the core's 32x32 register file. Adds configurable width, depth and read-port count, two write ports (ALU and load writeback), and write-to-read bypass. Also holds a per-register scoreboard of pending writes plus a registered busy count, so the hazard unit can stall on operands not yet produced. Sits in the decode stage, replacing the single-write-port file.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two)
AW, 5, register address width; log2(NREGS)
NRD, 2, number of read ports
ZERO_REG, 1, when 1 register 0 is hardwired zero and never busy

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
rd_busy  output  NRD  port k operand has a pending write not bypassed this cycle
wr0_en  input  1  write port 0 enable (ALU writeback)
wr0_addr  input  AW  write port 0 destination
wr0_data  input  XLEN  write port 0 data
wr1_en  input  1  write port 1 enable (load writeback)
wr1_addr  input  AW  write port 1 destination
wr1_data  input  XLEN  write port 1 data
sb_set  input  1  issue: mark sb_addr busy
sb_addr  input  AW  destination of issuing instruction
flush  input  1  pipeline flush: clear entire scoreboard
busy_cnt  output  AW+1  registered count of busy registers

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately including mid-operation): all registers 0, busy vector 0, busy_cnt 0. rd_data reads 0 and rd_busy reads 0 while in reset.
- Data write on a rising edge: wrN_en high and (ZERO_REG==0 or wrN_addr!=0) writes wrN_data to wrN_addr.
- Both ports writing the same address: port 1 wins.
- Reads are combinational. If a port's address matches an active, legal write this cycle, rd_data returns that write data, with port 1 taking priority over port 0. Otherwise rd_data returns the stored value.
- With ZERO_REG=1, address 0 always reads 0 with rd_busy 0 and is never bypassed.
- Scoreboard next-state per register r, in priority order:
  1. flush: busy[r]=0. Data writes still occur.
  2. sb_set and sb_addr==r: busy[r]=1. Set beats a same-cycle writeback clear, because the issuing instruction is the newer producer.
  3. An active write to r on either port: busy[r]=0.
  4. Otherwise hold.
- sb_set to register 0 is ignored when ZERO_REG=1.
- sb_set to an already-busy register (WAW) leaves it busy.
- A write to a non-busy register is legal; data is written and the scoreboard is unchanged.
- rd_busy[k] = busy[rd_addr_k] AND NOT (active same-cycle write to rd_addr_k). rd_busy is computed from current state, not next state.
- busy_cnt: registered; after every edge it equals the popcount of the busy vector. Range 0..NREGS; width AW+1 so NREGS fits without wrap.
- Latency: write visible on rd_data in the same cycle via bypass and from storage from the next cycle. Busy set is visible on rd_busy the cycle after sb_set.
- Out-of-range addresses cannot occur (NREGS = 2^AW).

Test Plan:
- Reset then read: after reset_n deasserts, rd_addr={3,7} -> rd_data={0,0}, rd_busy=0, busy_cnt=0. Write x5=0xDEADBEEF via wr0, next cycle read x5 -> 0xDEADBEEF.
- Bypass/priority: same cycle wr0 x9=0x11, wr1 x9=0x22, read x9 -> 0x22 combinationally; next cycle x9 stored 0x22. wr1 x0=0xFFFFFFFF -> x0 reads 0.
- Scoreboard: sb_set x4 -> next cycle rd_busy=1, busy_cnt=1. wr1 x4=0x55 -> that cycle rd_busy=0 and rd_data=0x55; next cycle busy_cnt=0.
- Set/clear collision: x6 busy, same cycle wr0 x6 and sb_set x6 -> x6 still busy, busy_cnt unchanged, data updated.
- Flush: set x1,x2,x3 on successive cycles (busy_cnt=3), then flush together with sb_set x8 -> next cycle busy_cnt=0 and x8 not busy.
- Async reset mid-run: registers loaded and busy_cnt=2, drop reset_n between edges -> outputs 0 immediately without a clock edge.
